// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
// Also provides a sizing helper so parents can pick a digit count for a given width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NIB_THRESH = 4'd5;
  localparam logic [3:0] NIB_ADJUST = 4'd3;
  localparam logic [3:0] NIB_SAT    = 4'd9;

  // ceil(width * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int bcd_min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble nibble cell: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= NIB_THRESH) ? (nib_in + NIB_ADJUST) : nib_in;

endmodule

// File: rtl/bcd_converter_serial.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle,
// valid/ready on both sides, saturating to all nines on overflow.
module bcd_converter_serial
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{NIB_SAT}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj, bcd_shift;
  logic             ovf_q, ovf_d;
  logic             carry_out;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic             out_ovf_q, out_ovf_d;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .nib_in  (bcd_q[4*gi +: 4]),
        .nib_out (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // A 1 leaving the top nibble means the value so far already exceeds DIGITS digits.
  assign {carry_out, bcd_shift} = {bcd_adj, bin_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    out_bcd_d = out_bcd_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_data;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        ovf_d = ovf_q | carry_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          out_bcd_d = ovf_d ? SAT_BCD : bcd_shift;
          out_ovf_d = ovf_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      out_bcd_q <= out_bcd_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bcd      = out_bcd_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_bcd_converter_serial.sv
// Directed bench for the serial BCD converter: three instances (16/5, 16/4, 5/2)
// share the input side and out_ready; each result port is checked separately.
module tb_bcd_converter_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_overflow;
  logic [19:0] a_out_bcd;
  logic        b_in_ready, b_out_valid, b_out_overflow;
  logic [15:0] b_out_bcd;
  logic        c_in_ready, c_out_valid, c_out_overflow;
  logic [7:0]  c_out_bcd;

  int checks = 0;
  int errors = 0;

  bcd_converter_serial #(.WIDTH(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_bcd(a_out_bcd), .out_overflow(a_out_overflow)
  );

  bcd_converter_serial #(.WIDTH(16), .DIGITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_bcd(b_out_bcd), .out_overflow(b_out_overflow)
  );

  bcd_converter_serial #(.WIDTH(5), .DIGITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data[4:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_bcd(c_out_bcd), .out_overflow(c_out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction with out_ready high; returns every instance's result and latency.
  task automatic convert(input logic [15:0] v,
                         output int lat_a, output logic [19:0] bcd_a, output logic ovf_a,
                         output logic [15:0] bcd_b, output logic ovf_b,
                         output int lat_c, output logic [7:0] bcd_c, output logic ovf_c);
    bit got_c;
    lat_a = -1; lat_c = -1; got_c = 0;
    bcd_a = '0; ovf_a = 0; bcd_b = '0; ovf_b = 0; bcd_c = '0; ovf_c = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = v; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (c_out_valid && !got_c) begin
        got_c = 1; lat_c = i; bcd_c = c_out_bcd; ovf_c = c_out_overflow;
      end
      if (a_out_valid) begin
        lat_a = i; bcd_a = a_out_bcd; ovf_a = a_out_overflow;
        bcd_b = b_out_bcd; ovf_b = b_out_overflow;
        break;
      end
    end
    @(posedge clk); #1;
    $display("txn in=%0d lat=%0d bcd5=%h ovf5=%0b bcd4=%h ovf4=%0b bcd2=%h ovf2=%0b",
             v, lat_a, bcd_a, ovf_a, bcd_b, ovf_b, bcd_c, ovf_c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_bcd !== 20'h0) begin errors++; $display("FAIL reset_out_bcd got=%h exp=00000", a_out_bcd); end
    checks++; if (a_out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", a_out_overflow); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle ready=%b valid=%b exp ready=1 valid=0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_convert_d5();
    logic [15:0] vin [3];
    logic [19:0] vexp [3];
    int la, lc; logic [19:0] ba; logic oa; logic [15:0] bb; logic ob; logic [7:0] bc; logic oc;
    vin[0] = 16'd12345; vexp[0] = 20'h12345;
    vin[1] = 16'd0;     vexp[1] = 20'h00000;
    vin[2] = 16'd65535; vexp[2] = 20'h65535;
    for (int k = 0; k < 3; k++) begin
      convert(vin[k], la, ba, oa, bb, ob, lc, bc, oc);
      checks++; if (la != 16) begin errors++; $display("FAIL d5_latency in=%0d got=%0d exp=16", vin[k], la); end
      checks++; if (ba !== vexp[k]) begin errors++; $display("FAIL d5_bcd in=%0d got=%h exp=%h", vin[k], ba, vexp[k]); end
      checks++; if (oa !== 1'b0) begin errors++; $display("FAIL d5_overflow in=%0d got=%b exp=0", vin[k], oa); end
    end
  endtask

  task automatic test_overflow_d4();
    logic [15:0] vin [3];
    logic [15:0] vexp [3];
    logic        oexp [3];
    int la, lc; logic [19:0] ba; logic oa; logic [15:0] bb; logic ob; logic [7:0] bc; logic oc;
    vin[0] = 16'd9999;  vexp[0] = 16'h9999; oexp[0] = 1'b0;
    vin[1] = 16'd10000; vexp[1] = 16'h9999; oexp[1] = 1'b1;
    vin[2] = 16'd65535; vexp[2] = 16'h9999; oexp[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      convert(vin[k], la, ba, oa, bb, ob, lc, bc, oc);
      checks++; if (bb !== vexp[k]) begin errors++; $display("FAIL d4_bcd in=%0d got=%h exp=%h", vin[k], bb, vexp[k]); end
      checks++; if (ob !== oexp[k]) begin errors++; $display("FAIL d4_overflow in=%0d got=%b exp=%b", vin[k], ob, oexp[k]); end
    end
  endtask

  task automatic test_exhaustive_w5();
    int la, lc; logic [19:0] ba; logic oa; logic [15:0] bb; logic ob; logic [7:0] bc; logic oc;
    logic [7:0] exp_c;
    for (int n = 0; n < 32; n++) begin
      exp_c = {4'(n / 10), 4'(n % 10)};
      convert(16'(n), la, ba, oa, bb, ob, lc, bc, oc);
      checks++; if (bc !== exp_c) begin errors++; $display("FAIL w5_bcd in=%0d got=%h exp=%h", n, bc, exp_c); end
      checks++; if (oc !== 1'b0) begin errors++; $display("FAIL w5_overflow in=%0d got=%b exp=0", n, oc); end
      checks++; if (lc != 5) begin errors++; $display("FAIL w5_latency in=%0d got=%0d exp=5", n, lc); end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd4321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = a_out_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_out_valid_timeout got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3); in_data = 16'd777;
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_bcd !== 20'h04321 || a_out_overflow !== 1'b0 || a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b bcd=%h ovf=%b ready=%b exp valid=1 bcd=04321 ovf=0 ready=0",
                 i, a_out_valid, a_out_bcd, a_out_overflow, a_in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release ready=%b valid=%b exp ready=1 valid=0", a_in_ready, a_out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_bcd !== 20'h04321) begin
      errors++; $display("FAIL bp_ignored_777 ready=%b bcd=%h exp ready=1 bcd=04321", a_in_ready, a_out_bcd);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] res_bcd [3];
    int          res_cyc [3];
    int          nres;
    int          nxt;
    bit          acc;
    nres = 0; nxt = 1;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd1;
    for (int cyc = 0; cyc < 80 && nres < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      acc = a_in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) begin
        if (nxt == 3) in_valid = 1'b0;
        else begin nxt++; in_data = 16'(nxt); end
      end
      if (a_out_valid) begin
        res_bcd[nres] = a_out_bcd; res_cyc[nres] = cyc; nres++;
      end
    end
    in_valid = 1'b0;
    checks++; if (nres != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nres); end
    for (int k = 0; k < nres; k++) begin
      checks++; if (res_bcd[k] !== 20'(k + 1)) begin
        errors++; $display("FAIL b2b_value idx=%0d got=%h exp=%h", k, res_bcd[k], 20'(k + 1));
      end
    end
    for (int k = 1; k < nres; k++) begin
      checks++; if (res_cyc[k] - res_cyc[k-1] != 18) begin
        errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=18", k, res_cyc[k] - res_cyc[k-1]);
      end
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int la, lc; logic [19:0] ba; logic oa; logic [15:0] bb; logic ob; logic [7:0] bc; logic oc;
    bit seen;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd54321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_shift_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_bcd !== 20'h0) begin errors++; $display("FAIL rst_shift_out_bcd got=%h exp=00000", a_out_bcd); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_shift_in_ready got=%b exp=1", a_in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    convert(16'd42, la, ba, oa, bb, ob, lc, bc, oc);
    checks++; if (ba !== 20'h00042) begin errors++; $display("FAIL rst_after_bcd got=%h exp=00042", ba); end
    checks++; if (la != 16) begin errors++; $display("FAIL rst_after_latency got=%0d exp=16", la); end
    // Reset while holding a result in DONE.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = a_out_valid;
    end
    checks++; if (!seen || a_out_bcd !== 20'h00099) begin
      errors++; $display("FAIL rst_done_setup valid=%b bcd=%h exp valid=1 bcd=00099", seen, a_out_bcd);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_bcd !== 20'h0) begin
      errors++; $display("FAIL rst_done_drop valid=%b bcd=%h exp valid=0 bcd=00000", a_out_valid, a_out_bcd);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_convert_d5();
    test_overflow_d4();
    test_exhaustive_w5();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
